ppu_cfg_loader: RTL and testbench

- Responder end of the PPU configuration byte-stream handshake.
- Accepts a sync-framed burst of 8-bit words on data_i/stb_i, acknowledges each with a one-cycle ack_o pulse, and stores them in an indexed register bank.
- Raises cfg_valid when a complete frame has been loaded.
- Sits inside the PPU, between the host/test sequencer and the pattern generator, which reads parameters through a combinational read port.

---
 rtl/ppu_cfg_loader_pkg.sv | 25 ++
 rtl/ppu_cfg_loader_if.sv | 15 +
 rtl/ppu_cfg_loader.sv | 162 ++++++++++++++++
 tb/tb_ppu_cfg_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_cfg_loader_pkg.sv
// ppu_cfg_pkg: shared types and constants for the PPU configuration loader.
// Optional build macro used by the loader: PPU_CFG_CHECKSUM_EN.
package ppu_cfg_pkg;

  // Loader state machine, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } cfg_state_e;

  localparam int NWORDS_DEFAULT = 10;
  localparam int CFG_CKSUM_W    = 8;
  localparam int CFG_WORD_W     = 8;

  // Running frame checksum: plain sum modulo 2**CFG_CKSUM_W.
  function automatic logic [CFG_CKSUM_W-1:0] cksum_add(
    input logic [CFG_CKSUM_W-1:0] acc,
    input logic [CFG_WORD_W-1:0]  word
  );
    return acc + word;
  endfunction

endpackage

// File: rtl/ppu_cfg_loader_if.sv
// ppu_cfg_loader_if: configuration byte-stream handshake between the
// host/test sequencer (master) and the PPU config loader (slave).
interface ppu_cfg_loader_if;
  import ppu_cfg_pkg::*;

  logic                  sync;
  logic [2:0]            mode_i;
  logic [CFG_WORD_W-1:0] data_i;
  logic                  stb_i;
  logic                  ack_o;

  modport master (output sync, output mode_i, output data_i, output stb_i, input ack_o);
  modport slave  (input sync, input mode_i, input data_i, input stb_i, output ack_o);

endinterface

// File: rtl/ppu_cfg_loader.sv
// ppu_cfg_loader: responder end of the PPU configuration handshake.
// Loads a sync-framed burst of bytes into an indexed register bank, acks
// each accepted word with a one-cycle pulse and flags complete, aborted or
// overrun frames. Build macro PPU_CFG_CHECKSUM_EN appends a checksum word
// (sum mod 256 of the data words) that is acked, checked and not stored.
module ppu_cfg_loader
  import ppu_cfg_pkg::*;
#(
  parameter int NWORDS = NWORDS_DEFAULT,
  parameter int AW     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ppu_cfg_loader_if.slave       bus,
  input  logic [AW-1:0]         rd_addr,
  output logic [CFG_WORD_W-1:0] rd_data,
  output logic [2:0]            cfg_mode,
  output logic                  cfg_valid,
  output logic                  cfg_err,
  output logic [AW-1:0]         word_cnt
);

`ifdef PPU_CFG_CHECKSUM_EN
  localparam int FRAME_LEN_I = NWORDS + 1;
`else
  localparam int FRAME_LEN_I = NWORDS;
`endif
  localparam logic [AW-1:0] FRAME_LEN = AW'(FRAME_LEN_I);
  localparam logic [AW-1:0] NWORDS_A  = AW'(NWORDS);

  cfg_state_e            state_r;
  logic [AW-1:0]         cnt_r;
  logic                  ack_r;
  logic                  valid_r;
  logic                  err_r;
  logic [2:0]            mode_r;
  logic [CFG_WORD_W-1:0] regs_r [NWORDS];
  logic                  wr_en_s;
`ifdef PPU_CFG_CHECKSUM_EN
  logic [CFG_CKSUM_W-1:0] sum_r;
  logic                   cksum_ok_r;
`endif

  // Store strobe: accepted data words only (a trailing checksum word is not stored).
  always_comb begin
    wr_en_s = 1'b0;
    if ((state_r == LOAD) && bus.sync && bus.stb_i && (cnt_r < NWORDS_A)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Frame sequencing: start, accept/ack, gap, done, abort and overrun handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      ack_r      <= 1'b0;
      valid_r    <= 1'b0;
      err_r      <= 1'b0;
      mode_r     <= 3'd0;
`ifdef PPU_CFG_CHECKSUM_EN
      sum_r      <= '0;
      cksum_ok_r <= 1'b0;
`endif
    end else begin
      ack_r <= 1'b0;
      case (state_r)
        // Sync is always low on the way back to IDLE (abort or end of frame),
        // so a high sync here is a genuinely new frame.
        IDLE: begin
          if (bus.sync) begin
            mode_r     <= bus.mode_i;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            cnt_r      <= '0;
`ifdef PPU_CFG_CHECKSUM_EN
            sum_r      <= '0;
            cksum_ok_r <= 1'b0;
`endif
            state_r    <= LOAD;
          end
        end
        LOAD: begin
          if (!bus.sync) begin
            err_r   <= 1'b1;
            state_r <= IDLE;
          end else if (bus.stb_i) begin
            ack_r <= 1'b1;
            if (cnt_r < FRAME_LEN) begin
              cnt_r <= cnt_r + AW'(1);
            end
`ifdef PPU_CFG_CHECKSUM_EN
            if (cnt_r < NWORDS_A) begin
              sum_r <= cksum_add(sum_r, bus.data_i);
            end else begin
              cksum_ok_r <= (sum_r == bus.data_i);
            end
`endif
            state_r <= GAP;
          end
        end
        // One dead cycle after every accept so a held strobe is not re-taken.
        GAP: begin
          if (cnt_r == FRAME_LEN) begin
`ifdef PPU_CFG_CHECKSUM_EN
            valid_r <= cksum_ok_r;
            err_r   <= ~cksum_ok_r;
`else
            valid_r <= 1'b1;
`endif
            state_r <= DONE;
          end else if (!bus.sync) begin
            err_r   <= 1'b1;
            state_r <= IDLE;
          end else begin
            state_r <= LOAD;
          end
        end
        DONE: begin
          if (!bus.sync) begin
            state_r <= IDLE;
          end else if (bus.stb_i) begin
            err_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Register bank: cleared by reset, written at the current word index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      regs_r[cnt_r] <= bus.data_i;
    end
  end

  // Consumer read port; indices past the bank read as zero.
  always_comb begin
    rd_data = '0;
    if (rd_addr < NWORDS_A) begin
      rd_data = regs_r[rd_addr];
    end else begin
      rd_data = '0;
    end
  end

  assign bus.ack_o = ack_r;
  assign cfg_mode  = mode_r;
  assign cfg_valid = valid_r;
  assign cfg_err   = err_r;
  assign word_cnt  = cnt_r;

endmodule

// File: tb/tb_ppu_cfg_loader.sv
// tb_ppu_cfg_loader: directed plus randomized checks of ppu_cfg_loader
// against a frame-level reference model. Honours PPU_CFG_CHECKSUM_EN.
module tb_ppu_cfg_loader;

  localparam int NWORDS = 10;
  localparam int AW     = 4;
`ifdef PPU_CFG_CHECKSUM_EN
  localparam int FL = NWORDS + 1;
`else
  localparam int FL = NWORDS;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [2:0]    cfg_mode;
  logic          cfg_valid;
  logic          cfg_err;
  logic [AW-1:0] word_cnt;

  ppu_cfg_loader_if bus ();

  ppu_cfg_loader #(.NWORDS(NWORDS), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .cfg_mode  (cfg_mode),
    .cfg_valid (cfg_valid),
    .cfg_err   (cfg_err),
    .word_cnt  (word_cnt)
  );

  always #50 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: frame-level view of the loader outputs.
  int m_regs [16];
  int m_mode;
  int m_valid;
  int m_err;
  int m_cnt;
  int frm [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    m_mode = 0; m_valid = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_valid"}, 32'(cfg_valid), 32'(m_valid));
    chk({tag, "_err"},   32'(cfg_err),   32'(m_err));
    chk({tag, "_mode"},  32'(cfg_mode),  32'(m_mode));
    chk({tag, "_cnt"},   32'(word_cnt),  32'(m_cnt));
  endtask

  task automatic chk_regs(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = AW'(a);
      #1;
      chk({tag, "_rd"}, 32'(rd_data), (a < NWORDS) ? 32'(m_regs[a]) : 32'd0);
    end
  endtask

  // Checksum word for the current data words in frm.
  task automatic fill_cksum();
    int s;
    s = 0;
    for (int i = 0; i < NWORDS; i++) s += frm[i];
    frm[NWORDS] = s % 256;
  endtask

  // Stream n words of frm with stb held high, advancing data only on ack.
  task automatic run_frame(input int n, input int mode);
    int idx, last, cyc;
    bus.sync = 1'b0; bus.stb_i = 1'b0;
    step();
    bus.sync = 1'b1; bus.mode_i = 3'(mode); bus.stb_i = 1'b1; bus.data_i = 8'(frm[0]);
    idx = 0; last = 0; cyc = 0;
    while (idx < n && cyc < 4 * FL + 8) begin
      step();
      cyc++;
      if (bus.ack_o === 1'b1) begin
        chk("ack_spacing", 32'(cyc - last), 32'd2);
        chk("ack_wordcnt", 32'(word_cnt), 32'(idx + 1));
        last = cyc;
        idx++;
        if (idx < n) bus.data_i = 8'(frm[idx]);
      end
    end
    chk("ack_total", 32'(idx), 32'(n));
    bus.stb_i = 1'b0;
    m_mode = mode; m_valid = 0; m_err = 0; m_cnt = idx;
    for (int i = 0; i < idx && i < NWORDS; i++) m_regs[i] = frm[i];
  endtask

  // After a full frame: one cycle to reach the done state, then check.
  task automatic finish_frame(input string tag);
    int s;
    step();
    s = 0;
    for (int i = 0; i < NWORDS; i++) s += frm[i];
`ifdef PPU_CFG_CHECKSUM_EN
    m_valid = ((s % 256) == frm[NWORDS]) ? 1 : 0;
`else
    m_valid = 1;
`endif
    m_err = 1 - m_valid;
    chk_status(tag);
  endtask

  task automatic abort_frame(input string tag);
    bus.sync = 1'b0;
    step();
    m_err = 1;
    chk_status(tag);
  endtask

  task automatic end_frame();
    bus.sync = 1'b0;
    step();
  endtask

  task automatic load_nominal();
    int nom [10] = '{42, 123, 87, 255, 0, 198, 76, 34, 210, 99};
    for (int i = 0; i < NWORDS; i++) frm[i] = nom[i];
    fill_cksum();
  endtask

  initial begin
    rst = 1'b1;
    bus.sync = 1'b0; bus.stb_i = 1'b0; bus.data_i = 8'h00; bus.mode_i = 3'd0;
    rd_addr = '0;
    model_reset();
    #10;
    // Reset state, before any clock edge.
    chk("rst_ack", 32'(bus.ack_o), 32'd0);
    chk_status("rst");
    chk_regs("rst");
    step();
    rst = 1'b0;
    step();

    // Abort after 4 words on a freshly reset bank.
    for (int i = 0; i < NWORDS; i++) frm[i] = $urandom_range(1, 255);
    fill_cksum();
    run_frame(4, 5);
    abort_frame("abort");
    chk_regs("abort");
    end_frame();

    // Nominal frame.
    load_nominal();
    run_frame(FL, 1);
    finish_frame("nominal");
    rd_addr = 4'd3; #1; chk("nominal_addr3", 32'(rd_data), 32'd255);
    rd_addr = 4'd9; #1; chk("nominal_addr9", 32'(rd_data), 32'd99);
    chk_regs("nominal");

    // Overrun: frame complete, sync still high, one more strobe.
    bus.data_i = 8'h55; bus.stb_i = 1'b1;
    step();
    chk("overrun_ack0", 32'(bus.ack_o), 32'd0);
    bus.stb_i = 1'b0;
    step();
    chk("overrun_ack1", 32'(bus.ack_o), 32'd0);
    m_err = 1;
    chk_status("overrun");
    chk_regs("overrun");
    end_frame();

    // Randomized frames, some cut short.
    for (int f = 0; f < 6; f++) begin
      int n, md;
      md = $urandom_range(0, 7);
      for (int i = 0; i < NWORDS; i++) frm[i] = $urandom_range(0, 255);
      fill_cksum();
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FL - 1) : FL;
      run_frame(n, md);
      if (n == FL) finish_frame("rand_full");
      else abort_frame("rand_abort");
      chk_regs("rand");
      end_frame();
    end

    // Held strobe with fixed data: one accept per two cycles, no ack in the gap.
    bus.sync = 1'b0; step();
    bus.sync = 1'b1; bus.mode_i = 3'd3; bus.stb_i = 1'b1; bus.data_i = 8'd42;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("held_cnt", 32'(word_cnt), 32'(k / 2));
      chk("held_ack", 32'(bus.ack_o), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus.stb_i = 1'b0;
    m_mode = 3; m_valid = 0; m_cnt = 3;
    for (int i = 0; i < 3; i++) m_regs[i] = 42;
    abort_frame("held");
    chk_regs("held");
    end_frame();

    // Reset in the middle of a frame.
    for (int i = 0; i < NWORDS; i++) frm[i] = $urandom_range(1, 255);
    fill_cksum();
    run_frame(5, 2);
    rst = 1'b1;
    bus.sync = 1'b0;
    #1;
    chk("midrst_ack", 32'(bus.ack_o), 32'd0);
    chk("midrst_cnt", 32'(word_cnt), 32'd0);
    model_reset();
    step();
    rst = 1'b0;
    chk_status("midrst");
    chk_regs("midrst");

    // Clean frame after the reset.
    load_nominal();
    run_frame(FL, 6);
    finish_frame("post_rst");
    chk_regs("post_rst");
    end_frame();

`ifdef PPU_CFG_CHECKSUM_EN
    // Bad checksum: data still stored, frame flagged.
    load_nominal();
    frm[NWORDS] = 101;
    run_frame(FL, 1);
    finish_frame("bad_cksum");
    chk("bad_cksum_valid", 32'(cfg_valid), 32'd0);
    chk_regs("bad_cksum");
    end_frame();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
